// File: rtl/step_scheduler.sv
// Step/dir pulse generator with a wishbone register file and a queue of moves, timed against a shared clock counter.
// Optional STEPSCHED_DIR_SETUP_EN: after a direction change, hold the first step for DIR_SETUP clocks.
module step_scheduler #(
    parameter int QUEUE_DEPTH = 4,
    parameter int IRQ_LEVEL   = 1,
    parameter int DIR_SETUP   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] counter,
    input  logic        shutdown,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        step,
    output logic        dir,
    output logic        irq
);
    // state | meaning
    // IDLE  | no move active; waits for armed and a queued entry
    // LOAD  | pops the head entry into the current-move registers
    // WAIT  | waits until counter reaches next_time (and any dir setup hold)
    // PULSE | step high for pulse_ticks cycles
    // GAP   | step low for pulse_ticks cycles, then next step / entry / idle
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_PULSE, S_GAP} state_t;

    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int SW = $clog2(DIR_SETUP + 2);
`ifdef STEPSCHED_DIR_SETUP_EN
    localparam logic [SW-1:0] SETUP_LD = SW'(DIR_SETUP - 1);
`else
    localparam logic [SW-1:0] SETUP_LD = '0;
`endif

    state_t        state_q;
    logic          ack_q;
    logic [31:0]   rdata_q;
    logic          step_q;
    logic          dir_q;
    logic          irq_q;
    logic [31:0]   interval_q;
    logic [31:0]   cnt_add_q;
    logic [7:0]    pulse_ticks_q;
    logic          irq_en_q;
    logic [31:0]   next_time_q;
    logic          armed_q;
    logic          overflow_q;
    logic          underrun_q;
    logic          shut_q;
    logic [31:0]   cur_interval_q;
    logic [15:0]   cur_count_q;
    logic [15:0]   cur_add_q;
    logic [7:0]    tick_q;
    logic          late_q;
    logic [SW-1:0] setup_q;
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;

    logic [31:0]   mem_int_q [QUEUE_DEPTH];
    logic [31:0]   mem_ca_q  [QUEUE_DEPTH];
    logic          mem_dir_q [QUEUE_DEPTH];

    logic          wb_req;
    logic          wb_wr;
    logic          wb_rd;
    logic [AW:0]   level_w;
    logic [31:0]   lvl32;
    logic [3:0]    lvl4;
    logic          fifo_empty;
    logic          fifo_full;
    logic          running;
    logic          pop;
    logic          push_req;
    logic          push_ok;
    logic          push_drop;
    logic [7:0]    pt_eff;
    logic [7:0]    pt_m1;
    logic [31:0]   late_by;
    logic          fire;
    logic [31:0]   new_interval;
    logic [31:0]   status_w;
    logic [31:0]   rdata_d;
    logic [31:0]   head_int;
    logic [31:0]   head_ca;
    logic          head_dir;

    assign wb_req     = wb_stb_i & wb_cyc_i & ~ack_q;
    assign wb_wr      = wb_req & wb_we_i;
    assign wb_rd      = wb_req & ~wb_we_i;

    assign level_w    = wr_ptr_q - rd_ptr_q;
    assign lvl32      = 32'(level_w);
    assign lvl4       = (lvl32 > 32'd15) ? 4'hF : lvl32[3:0];
    assign fifo_empty = (level_w == '0);
    assign fifo_full  = (lvl32 == 32'(QUEUE_DEPTH));
    assign running    = (state_q != S_IDLE);

    assign head_int   = mem_int_q[rd_ptr_q[AW-1:0]];
    assign head_ca    = mem_ca_q[rd_ptr_q[AW-1:0]];
    assign head_dir   = mem_dir_q[rd_ptr_q[AW-1:0]];

    // A pop in LOAD frees a slot in time for a push landing on the same edge.
    assign pop        = (state_q == S_LOAD) & ~shutdown;
    assign push_req   = wb_wr & (wb_adr_i == 4'd3) & ~shutdown & (cnt_add_q[31:16] != 16'd0);
    assign push_ok    = push_req & (~fifo_full | pop);
    assign push_drop  = push_req & fifo_full & ~pop;

    assign pt_eff     = (pulse_ticks_q == 8'd0) ? 8'd1 : pulse_ticks_q;
    assign pt_m1      = pt_eff - 8'd1;

    // Signed difference keeps the compare correct across counter wrap.
    assign late_by      = counter - next_time_q;
    assign fire         = (state_q == S_WAIT) & ~late_by[31] & (setup_q == '0);
    assign new_interval = cur_interval_q + {{16{cur_add_q[15]}}, cur_add_q};

    assign status_w = {23'd0, shut_q, underrun_q, overflow_q, armed_q, running, lvl4};

    always_comb begin
        rdata_d = 32'd0;
        case (wb_adr_i)
            4'd0:    rdata_d = status_w;
            4'd1:    rdata_d = interval_q;
            4'd2:    rdata_d = cnt_add_q;
            4'd5:    rdata_d = {23'd0, irq_en_q, pulse_ticks_q};
            default: rdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_int_q[wr_ptr_q[AW-1:0]] <= interval_q;
            mem_ca_q[wr_ptr_q[AW-1:0]]  <= cnt_add_q;
            mem_dir_q[wr_ptr_q[AW-1:0]] <= wb_dat_i[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            ack_q          <= 1'b0;
            rdata_q        <= 32'd0;
            step_q         <= 1'b0;
            dir_q          <= 1'b0;
            irq_q          <= 1'b0;
            interval_q     <= 32'd0;
            cnt_add_q      <= 32'd0;
            pulse_ticks_q  <= 8'd1;
            irq_en_q       <= 1'b0;
            next_time_q    <= 32'd0;
            armed_q        <= 1'b0;
            overflow_q     <= 1'b0;
            underrun_q     <= 1'b0;
            shut_q         <= 1'b0;
            cur_interval_q <= 32'd0;
            cur_count_q    <= 16'd0;
            cur_add_q      <= 16'd0;
            tick_q         <= 8'd0;
            late_q         <= 1'b0;
            setup_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
        end else begin
            ack_q <= wb_req;
            if (wb_req) begin
                rdata_q <= wb_rd ? rdata_d : 32'd0;
            end

            if (wb_wr) begin
                case (wb_adr_i)
                    4'd0: begin
                        if (wb_dat_i[6]) overflow_q <= 1'b0;
                        if (wb_dat_i[7]) underrun_q <= 1'b0;
                        if (wb_dat_i[8]) shut_q     <= 1'b0;
                    end
                    4'd1: interval_q <= wb_dat_i;
                    4'd2: cnt_add_q  <= wb_dat_i;
                    4'd4: begin
                        if (state_q == S_IDLE && !shutdown) begin
                            next_time_q <= wb_dat_i;
                            armed_q     <= 1'b1;
                        end
                    end
                    4'd5: begin
                        pulse_ticks_q <= wb_dat_i[7:0];
                        irq_en_q      <= wb_dat_i[8];
                    end
                    default: ;
                endcase
            end

            if (push_drop) overflow_q <= 1'b1;
            if (push_ok)   wr_ptr_q   <= wr_ptr_q + (AW+1)'(1);

            irq_q <= irq_en_q & ((running & (lvl32 <= 32'(IRQ_LEVEL)))
                                 | overflow_q | underrun_q | shut_q);

            if (shutdown) begin
                state_q  <= S_IDLE;
                step_q   <= 1'b0;
                rd_ptr_q <= wr_ptr_q;
                armed_q  <= 1'b0;
                shut_q   <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (armed_q && !fifo_empty) state_q <= S_LOAD;
                    end
                    S_LOAD: begin
                        rd_ptr_q       <= rd_ptr_q + (AW+1)'(1);
                        cur_interval_q <= head_int;
                        cur_count_q    <= head_ca[31:16];
                        cur_add_q      <= head_ca[15:0];
                        dir_q          <= head_dir;
                        setup_q        <= (head_dir != dir_q) ? SETUP_LD : '0;
                        state_q        <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (setup_q != '0) setup_q <= setup_q - SW'(1);
                        if (fire) begin
                            step_q         <= 1'b1;
                            tick_q         <= pt_m1;
                            next_time_q    <= next_time_q + cur_interval_q;
                            cur_interval_q <= new_interval;
                            cur_count_q    <= cur_count_q - 16'd1;
                            late_q         <= (late_by > cur_interval_q);
                            state_q        <= S_PULSE;
                        end
                    end
                    S_PULSE: begin
                        if (tick_q == 8'd0) begin
                            step_q  <= 1'b0;
                            tick_q  <= pt_m1;
                            state_q <= S_GAP;
                        end else begin
                            tick_q <= tick_q - 8'd1;
                        end
                    end
                    S_GAP: begin
                        if (tick_q != 8'd0) begin
                            tick_q <= tick_q - 8'd1;
                        end else if (cur_count_q != 16'd0) begin
                            state_q <= S_WAIT;
                        end else if (!fifo_empty) begin
                            state_q <= S_LOAD;
                        end else begin
                            state_q <= S_IDLE;
                            armed_q <= 1'b0;
                            if (late_q) underrun_q <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign wb_dat_o = rdata_q;
    assign wb_ack_o = ack_q;
    assign step     = step_q;
    assign dir      = dir_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_step_scheduler.sv
// Directed bench for step_scheduler: timing of step edges, FIFO flags, shutdown, counter wrap and dir setup.
module tb_step_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] free_q = 32'd0;
    logic [31:0] cnt_ofs = 32'd0;
    logic [31:0] counter;
    logic        shutdown = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [3:0]  wb_adr_i = 4'd0;
    logic [31:0] wb_dat_i = 32'd0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        step;
    logic        dir;
    logic        irq;

    int total = 0;
    int bad = 0;

`ifdef STEPSCHED_DIR_SETUP_EN
    localparam int EXP_SETUP = 16;
`else
    localparam int EXP_SETUP = 1;
`endif

    step_scheduler dut (
        .clk(clk), .rst_n(rst_n), .counter(counter), .shutdown(shutdown),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o), .step(step), .dir(dir), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) free_q <= free_q + 32'd1;
    assign counter = free_q + cnt_ofs;

    // Edge monitor: counter value at which each step fired, cycle of rise, pulse widths.
    logic [31:0] rise_t[$];
    logic [31:0] rise_c[$];
    int          widths[$];
    int          hi_n = 0;
    logic        step_d = 1'b0;
    logic        dir_d = 1'b0;
    logic [31:0] dir_c = 32'd0;

    always @(negedge clk) begin
        if (step && !step_d) begin
            rise_t.push_back(counter - 32'd1);
            rise_c.push_back(free_q);
        end
        if (step) hi_n = hi_n + 1;
        if (!step && step_d) begin
            widths.push_back(hi_n);
            hi_n = 0;
        end
        if (dir && !dir_d) dir_c = free_q;
        step_d = step;
        dir_d  = dir;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wb(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                      output logic [31:0] rd);
        int n;
        n = 0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
        do begin
            @(negedge clk);
            n++;
        end while (wb_ack_o !== 1'b1 && n < 8);
        check("wb_ack", {31'd0, wb_ack_o}, 32'd1);
        rd = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] dat);
        logic [31:0] d;
        wb(1'b1, adr, dat, d);
    endtask

    task automatic rdchk(input string tag, input logic [3:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        wb(1'b0, adr, 32'd0, d);
        check(tag, d, exp);
    endtask

    task automatic wait_rises(input string tag, input int n_abs, input int budget);
        int k;
        k = 0;
        while (rise_t.size() < n_abs && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, rise_t.size(), n_abs);
    endtask

    initial begin
        int r0;
        int w0;
        logic [31:0] t0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_step", step, 0);
        check("rst_dir", dir, 0);
        check("rst_irq", irq, 0);
        check("rst_ack", wb_ack_o, 0);
        check("rst_dat", wb_dat_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        rdchk("rst_status", 4'd0, 32'h0);
        rdchk("rst_config", 4'd5, 32'h1);

        // 1: three steps, 100 apart, 2 clocks wide
        wr(4'd5, 32'h2);
        wr(4'd1, 32'd100);
        wr(4'd2, {16'd3, 16'd0});
        wr(4'd3, 32'h1);
        r0 = rise_t.size();
        w0 = widths.size();
        t0 = counter + 32'd50;
        wr(4'd4, t0);
        wait_rises("t1_rises", r0 + 3, 400);
        repeat (8) @(negedge clk);
        check("t1_fire0", rise_t[r0], t0);
        check("t1_fire1", rise_t[r0+1], t0 + 32'd100);
        check("t1_fire2", rise_t[r0+2], t0 + 32'd200);
        check("t1_width0", widths[w0], 2);
        check("t1_width2", widths[w0+2], 2);
        check("t1_dir", dir, 1);
        check("t1_irq", irq, 0);
        rdchk("t1_status", 4'd0, 32'h0);

        // 2: negative add shrinks the interval each step
        wr(4'd5, 32'h1);
        wr(4'd1, 32'd1000);
        wr(4'd2, {16'd3, 16'hFF9C});
        wr(4'd3, 32'h0);
        r0 = rise_t.size();
        t0 = counter + 32'd20;
        wr(4'd4, t0);
        wait_rises("t2_rises", r0 + 3, 2500);
        check("t2_fire0", rise_t[r0], t0);
        check("t2_fire1", rise_t[r0+1], t0 + 32'd1000);
        check("t2_fire2", rise_t[r0+2], t0 + 32'd1900);
        repeat (6) @(negedge clk);
        check("t2_dir", dir, 0);
        rdchk("t2_status", 4'd0, 32'h0);

        // 3: schedule across counter wrap
        cnt_ofs = 32'hFFFFFF00 - free_q;
        wr(4'd1, 32'h20);
        wr(4'd2, {16'd2, 16'd0});
        wr(4'd3, 32'h0);
        r0 = rise_t.size();
        wr(4'd4, 32'hFFFFFFF0);
        wait_rises("t3_rises", r0 + 2, 600);
        check("t3_fire0", rise_t[r0], 32'hFFFFFFF0);
        check("t3_fire1", rise_t[r0+1], 32'h00000010);
        repeat (6) @(negedge clk);
        check("t3_nextra", rise_t.size(), r0 + 2);
        rdchk("t3_status", 4'd0, 32'h0);

        // 4: zero-count push ignored, overflow on 5th push, clear
        wr(4'd2, {16'd0, 16'd0});
        wr(4'd3, 32'h0);
        rdchk("t4_zero_cnt", 4'd0, 32'h0);
        wr(4'd5, 32'h102);
        wr(4'd1, 32'd100);
        wr(4'd2, {16'd2, 16'd0});
        repeat (4) wr(4'd3, 32'h0);
        rdchk("t4_full", 4'd0, 32'h04);
        wr(4'd3, 32'h0);
        rdchk("t4_overflow", 4'd0, 32'h44);
        check("t4_irq_ovf", irq, 1);
        rdchk("t4_unmapped", 4'd9, 32'h0);
        rdchk("t4_interval", 4'd1, 32'd100);
        rdchk("t4_config", 4'd5, 32'h102);
        wr(4'd0, 32'h40);
        rdchk("t4_cleared", 4'd0, 32'h04);
        @(negedge clk);
        check("t4_irq_clr", irq, 0);

        // 5: shutdown in the middle of a pulse
        r0 = rise_t.size();
        wr(4'd4, counter + 32'd10);
        wait_rises("t5_rise", r0 + 1, 100);
        check("t5_step_hi", step, 1);
        shutdown = 1'b1;
        @(negedge clk);
        check("t5_step_off", step, 0);
        wr(4'd3, 32'h0);
        wr(4'd4, counter + 32'd10);
        rdchk("t5_status", 4'd0, 32'h100);
        check("t5_irq", irq, 1);
        shutdown = 1'b0;
        wr(4'd0, 32'h100);
        rdchk("t5_cleared", 4'd0, 32'h0);

        // 6: overdue move pair with a direction change; late last step flags underrun
        wr(4'd5, 32'h1);
        wr(4'd1, 32'd10);
        wr(4'd2, {16'd1, 16'd0});
        wr(4'd3, 32'h0);
        wr(4'd3, 32'h1);
        r0 = rise_t.size();
        wr(4'd4, counter - 32'd500);
        wait_rises("t6_rises", r0 + 2, 200);
        check("t6_setup", rise_c[r0+1] - dir_c, EXP_SETUP);
        repeat (6) @(negedge clk);
        check("t6_dir", dir, 1);
        rdchk("t6_underrun", 4'd0, 32'h80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
